// File: rtl/fft_stage_sched.sv
// fft_stage_sched -- in-place radix-2 DIT FFT scheduler.
//
// Walks all LOG2N stages issuing one butterfly per cycle: a/b sample-memory
// read addresses plus a twiddle-ROM index. The returned samples are passed
// straight through to an external combinational butterfly, and its outputs
// are written back (registered) to the same two addresses two cycles after
// the read. Input samples are expected in bit-reversed order; the result
// ends up in natural order.
//
// Optional feature macro: FFT_SCHED_SCALE_EN
//   defined   : every written component is (x + 1) >>> 1, i.e. each stage
//               halves its output (1/N overall, no stage overflow).
//   undefined : write data is the butterfly output unmodified.
//   Control timing is the same in both builds.
//
// Ports (complex = [1:0][DATA_WIDTH-1:0], [0]=Re, [1]=Im)
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   start_i              start request, only looked at in IDLE
//   busy_o, done_o       transform in progress / one-cycle completion pulse
//   stage_o              stage currently being read (0 in IDLE/DONE)
//   rd_en_o              read strobe for sample memory and twiddle ROM
//   rd_addr_a_o/_b_o     read addresses of the a/b samples
//   twid_idx_o           twiddle index k, W = exp(-j*2*pi*k/N)
//   rd_data_a_i/_b_i     memory data, valid one cycle after rd_en_o
//   bfly_a_o/_b_o        to the butterfly inputs (combinational)
//   bfly_a_i/_b_i        from the butterfly outputs
//   wr_en_o              write strobe for both memory ports
//   wr_addr_a_o/_b_o     write addresses (equal to the read two cycles earlier)
//   wr_data_a_o/_b_o     registered write data
module fft_stage_sched #(
  parameter  int N_POINTS   = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAC_BITS  = 15,
  localparam int LOG2N      = $clog2(N_POINTS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [LOG2N-1:0]             stage_o,
  output logic                         rd_en_o,
  output logic [LOG2N-1:0]             rd_addr_a_o,
  output logic [LOG2N-1:0]             rd_addr_b_o,
  output logic [LOG2N-2:0]             twid_idx_o,
  input  logic [1:0][DATA_WIDTH-1:0]   rd_data_a_i,
  input  logic [1:0][DATA_WIDTH-1:0]   rd_data_b_i,
  output logic [1:0][DATA_WIDTH-1:0]   bfly_a_o,
  output logic [1:0][DATA_WIDTH-1:0]   bfly_b_o,
  input  logic [1:0][DATA_WIDTH-1:0]   bfly_a_i,
  input  logic [1:0][DATA_WIDTH-1:0]   bfly_b_i,
  output logic                         wr_en_o,
  output logic [LOG2N-1:0]             wr_addr_a_o,
  output logic [LOG2N-1:0]             wr_addr_b_o,
  output logic [1:0][DATA_WIDTH-1:0]   wr_data_a_o,
  output logic [1:0][DATA_WIDTH-1:0]   wr_data_b_o
);

  localparam int HALF_N = N_POINTS / 2;
  localparam logic [LOG2N-2:0] J_LAST = (LOG2N-1)'(HALF_N - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

  // The twiddle format is Q2.FRAC_BITS and samples are Q(FRAC_BITS); a
  // fractional width that does not fit the sample word is a wiring error.
  if (FRAC_BITS >= DATA_WIDTH || N_POINTS < 4) begin : g_param_check
    $error("fft_stage_sched: unsupported N_POINTS/FRAC_BITS/DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state_reg;
  logic [LOG2N-2:0]             j_reg;
  logic                         drain_reg;
  // one-deep delay of the read strobe/addresses; the second stage is wr_*_o
  logic                         p1_en_reg;
  logic [LOG2N-1:0]             p1_addr_a_reg;
  logic [LOG2N-1:0]             p1_addr_b_reg;

  logic [LOG2N-2:0]             issue_j;
  logic [LOG2N-1:0]             issue_s;
  logic [LOG2N-1:0]             issue_a;
  logic [LOG2N-1:0]             issue_b;
  logic [LOG2N-2:0]             issue_tw;
  logic [1:0][DATA_WIDTH-1:0]   wr_next_a;
  logic [1:0][DATA_WIDTH-1:0]   wr_next_b;

  // a = ((j >> s) << (s+1)) | (j & (half-1)): insert a zero at bit s of j
  function automatic logic [LOG2N-1:0] addr_a(input logic [LOG2N-2:0] j,
                                              input logic [LOG2N-1:0] s);
    logic [LOG2N-1:0] jw;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] k;
    jw   = {1'b0, j};
    half = LOG2N'(1) << s;
    k    = jw & (half - LOG2N'(1));
    return ((jw >> s) << (s + 1'b1)) | k;
  endfunction

  function automatic logic [LOG2N-2:0] twid(input logic [LOG2N-2:0] j,
                                            input logic [LOG2N-1:0] s);
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] k;
    logic [LOG2N-1:0] tw;
    half = LOG2N'(1) << s;
    k    = {1'b0, j} & (half - LOG2N'(1));
    tw   = k << (S_LAST - s);
    return tw[LOG2N-2:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
`ifdef FFT_SCHED_SCALE_EN
    logic signed [DATA_WIDTH:0] w;
    // one extra bit so x + 1 cannot wrap before the halving
    w = $signed({x[DATA_WIDTH-1], x}) + $signed((DATA_WIDTH+1)'(1));
    w = w >>> 1;
    return w[DATA_WIDTH-1:0];
`else
    return x;
`endif
  endfunction

  // The butterfly that is issued next: the following j within RUN, j=0 of
  // the next stage out of DRAIN, or j=0 of stage 0 out of IDLE (stage_o is 0
  // there). Only consumed on the edges where a read is actually launched.
  assign issue_j  = (state_reg == RUN)   ? j_reg + 1'b1   : '0;
  assign issue_s  = (state_reg == DRAIN) ? stage_o + 1'b1 : stage_o;
  assign issue_a  = addr_a(issue_j, issue_s);
  assign issue_b  = issue_a + (LOG2N'(1) << issue_s);
  assign issue_tw = twid(issue_j, issue_s);

  // Butterfly feed is a pure pass-through, forced to zero while in reset.
  assign bfly_a_o = rst_i ? '0 : rd_data_a_i;
  assign bfly_b_o = rst_i ? '0 : rd_data_b_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_wr_data
    assign wr_next_a[gi] = scale(bfly_a_i[gi]);
    assign wr_next_b[gi] = scale(bfly_b_i[gi]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      j_reg         <= '0;
      drain_reg     <= 1'b0;
      stage_o       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      rd_en_o       <= 1'b0;
      rd_addr_a_o   <= '0;
      rd_addr_b_o   <= '0;
      twid_idx_o    <= '0;
      p1_en_reg     <= 1'b0;
      p1_addr_a_reg <= '0;
      p1_addr_b_reg <= '0;
      wr_en_o       <= 1'b0;
      wr_addr_a_o   <= '0;
      wr_addr_b_o   <= '0;
      wr_data_a_o   <= '0;
      wr_data_b_o   <= '0;
    end else begin
      done_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg   <= RUN;
            j_reg       <= '0;
            stage_o     <= '0;
            busy_o      <= 1'b1;
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= issue_a;
            rd_addr_b_o <= issue_b;
            twid_idx_o  <= issue_tw;
          end
        end

        RUN: begin
          if (j_reg == J_LAST) begin
            state_reg   <= DRAIN;
            drain_reg   <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            twid_idx_o  <= '0;
          end else begin
            j_reg       <= issue_j;
            rd_addr_a_o <= issue_a;
            rd_addr_b_o <= issue_b;
            twid_idx_o  <= issue_tw;
          end
        end

        // Two idle read slots so the last write of this stage lands before
        // the first read of the next stage.
        DRAIN: begin
          if (!drain_reg) begin
            drain_reg <= 1'b1;
          end else if (stage_o == S_LAST) begin
            state_reg <= DONE;
            stage_o   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end else begin
            state_reg   <= RUN;
            j_reg       <= '0;
            stage_o     <= issue_s;
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= issue_a;
            rd_addr_b_o <= issue_b;
            twid_idx_o  <= issue_tw;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Write-back pipeline: read at t, data at t+1, write at t+2.
      p1_en_reg     <= rd_en_o;
      p1_addr_a_reg <= rd_addr_a_o;
      p1_addr_b_reg <= rd_addr_b_o;
      wr_en_o       <= p1_en_reg;
      wr_addr_a_o   <= p1_en_reg ? p1_addr_a_reg : '0;
      wr_addr_b_o   <= p1_en_reg ? p1_addr_b_reg : '0;
      wr_data_a_o   <= p1_en_reg ? wr_next_a : '0;
      wr_data_b_o   <= p1_en_reg ? wr_next_b : '0;
    end
  end

endmodule

// File: tb/tb_fft_stage_sched.sv
// Bench for fft_stage_sched (N=16, 16-bit samples, Q2.15 twiddles).
// Provides a behavioural sample memory, twiddle ROM and butterfly; every
// issued read pushes the expected address/twiddle and the expected write
// (computed from the bench's own memory copy) into queues that are popped
// when the scheduler produces reads and writes.
module tb_fft_stage_sched;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int LG = 4;

`ifdef FFT_SCHED_SCALE_EN
  localparam logic [15:0] IMP_RE = 16'h0400;
  localparam logic [15:0] DC_RE  = 16'h0400;
`else
  localparam logic [15:0] IMP_RE = 16'h4000;
  // DC input 0x0400 summed over 16 points gives 0x4000
  localparam logic [15:0] DC_RE  = 16'h4000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [LG-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LG-2:0] twid_idx;
  logic [1:0][DW-1:0] rd_data_a, rd_data_b, bfly_a_o, bfly_b_o;
  logic [1:0][DW-1:0] bfly_a_i, bfly_b_i, wr_data_a, wr_data_b;

  always #5 clk = ~clk;

  fft_stage_sched #(.N_POINTS(N), .DATA_WIDTH(DW), .FRAC_BITS(15)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .stage_o(stage),
    .rd_en_o(rd_en), .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b),
    .twid_idx_o(twid_idx),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b),
    .bfly_a_o(bfly_a_o), .bfly_b_o(bfly_b_o),
    .bfly_a_i(bfly_a_i), .bfly_b_i(bfly_b_i),
    .wr_en_o(wr_en), .wr_addr_a_o(wr_addr_a), .wr_addr_b_o(wr_addr_b),
    .wr_data_a_o(wr_data_a), .wr_data_b_o(wr_data_b)
  );

  // ---------------- behavioural memory, ROM, butterfly ----------------
  logic [1:0][DW-1:0] mem [N];
  logic [17:0] rom_re [N/2];
  logic [17:0] rom_im [N/2];
  logic [17:0] tw_re_q = '0;
  logic [17:0] tw_im_q = '0;
  logic        ld_en = 1'b0;
  logic [LG-1:0] ld_addr = '0;
  logic [1:0][DW-1:0] ld_data = '0;

  initial begin
    for (int k = 0; k < N/2; k++) begin
      real c, s;
      int ci, si;
      c  = $cos(2.0 * 3.14159265358979 * k / N) * 32768.0;
      s  = -$sin(2.0 * 3.14159265358979 * k / N) * 32768.0;
      ci = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
      si = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
      rom_re[k] = ci[17:0];
      rom_im[k] = si[17:0];
    end
  end

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      tw_re_q   <= rom_re[twid_idx];
      tw_im_q   <= rom_im[twid_idx];
    end
    if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // a' = a + W*b, b' = a - W*b, product rounded back to Q15
  function automatic logic [3:0][15:0] bf(input logic [15:0] ar, ai, br, bi,
                                          input logic [17:0] wr, wi);
    logic signed [35:0] pr, pi;
    logic [3:0][15:0] res;
    pr = $signed(br) * $signed(wr) - $signed(bi) * $signed(wi);
    pi = $signed(br) * $signed(wi) + $signed(bi) * $signed(wr);
    pr = (pr + 36'sd16384) >>> 15;
    pi = (pi + 36'sd16384) >>> 15;
    res[0] = ar + pr[15:0];
    res[1] = ai + pi[15:0];
    res[2] = ar - pr[15:0];
    res[3] = ai - pi[15:0];
    return res;
  endfunction

  function automatic logic [15:0] scl(input logic [15:0] x);
`ifdef FFT_SCHED_SCALE_EN
    int v;
    v = (int'($signed(x)) + 1) >>> 1;
    return v[15:0];
`else
    return x;
`endif
  endfunction

  logic [3:0][15:0] bf_out;
  always_comb bf_out = bf(bfly_a_o[0], bfly_a_o[1], bfly_b_o[0], bfly_b_o[1], tw_re_q, tw_im_q);
  assign bfly_a_i = {bf_out[1], bf_out[0]};
  assign bfly_b_i = {bf_out[3], bf_out[2]};

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [3:0] a, b, s;
    logic [2:0] tw;
  } rd_t;

  typedef struct {
    int         cyc;
    logic [3:0] a, b;
    logic [3:0][15:0] d;
  } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  cyc = 0;
  int  busy_cnt = 0;
  int  done_cnt = 0;
  bit  prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_after_busy", {63'd0, prev_busy & ~busy}, 64'd1);
      end
      prev_busy = busy;
      if (rd_en) begin
        if (rq.size() == 0) begin
          check("rd_unexpected", 64'd1, 64'd0);
        end else begin
          rd_t r;
          wr_t w;
          logic [3:0][15:0] d;
          r = rq.pop_front();
          check("rd_a", 64'(rd_addr_a), 64'(r.a));
          check("rd_b", 64'(rd_addr_b), 64'(r.b));
          check("rd_tw", 64'(twid_idx), 64'(r.tw));
          check("rd_stage", 64'(stage), 64'(r.s));
          d = bf(mem[r.a][0], mem[r.a][1], mem[r.b][0], mem[r.b][1], rom_re[r.tw], rom_im[r.tw]);
          for (int i = 0; i < 4; i++) d[i] = scl(d[i]);
          w.cyc = cyc + 2;
          w.a = r.a;
          w.b = r.b;
          w.d = d;
          wq.push_back(w);
        end
      end
      if (wr_en) begin
        if (wq.size() == 0) begin
          check("wr_unexpected", 64'd1, 64'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          $display("wr cyc=%0d a=%0d b=%0d da=%h db=%h", cyc, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b);
          check("wr_latency", 64'(cyc), 64'(w.cyc));
          check("wr_a", 64'(wr_addr_a), 64'(w.a));
          check("wr_b", 64'(wr_addr_b), 64'(w.b));
          check("wr_data_a", 64'(wr_data_a), 64'({w.d[1], w.d[0]}));
          check("wr_data_b", 64'(wr_data_b), 64'({w.d[3], w.d[2]}));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [3:0] bitrev(input logic [3:0] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[3-i];
    return r;
  endfunction

  // Expected read order written group-by-group, independent of j arithmetic
  task automatic push_reads();
    for (int s = 0; s < LG; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < (N/2) / half; g++) begin
        for (int k = 0; k < half; k++) begin
          rd_t r;
          int a;
          a    = g * 2 * half + k;
          r.a  = a[3:0];
          r.b  = 4'(a + half);
          r.tw = 3'(k * ((N/2) / half));
          r.s  = 4'(s);
          rq.push_back(r);
        end
      end
    end
  endtask

  // mode 0: impulse 0x4000 at x[0]; 1: DC 0x0400; 2: random
  task automatic load(input int mode);
    for (int n = 0; n < N; n++) begin
      logic [15:0] re, im;
      re = '0;
      im = '0;
      if (mode == 0) re = (n == 0) ? 16'h4000 : 16'h0000;
      else if (mode == 1) re = 16'h0400;
      else begin
        re = 16'($urandom_range(0, 4095)) - 16'd2048;
        im = 16'($urandom_range(0, 4095)) - 16'd2048;
      end
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = bitrev(4'(n));
      ld_data = {im, re};
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_fft(input bit hold, input bit poke);
    bit seen;
    seen = 1'b0;
    push_reads();
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (poke && i == 10) start = 1'b1;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    $display("run hold=%0d poke=%0d busy_cycles=%0d done_pulses=%0d", hold, poke, busy_cnt, done_cnt);
    check("busy_cycles", 64'(busy_cnt), 64'd40);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
    check("reads_left", 64'(rq.size()), 64'd0);
    check("writes_left", 64'(wq.size()), 64'd0);
  endtask

  task automatic check_bins(input string name, input logic [15:0] bin0, input logic [15:0] rest, input int tol);
    for (int n = 0; n < N; n++) begin
      logic [15:0] want, got_re, got_im;
      int d_re, d_im;
      want   = (n == 0) ? bin0 : rest;
      d_re   = int'($signed(mem[n][0])) - int'($signed(want));
      d_im   = int'($signed(mem[n][1]));
      got_re = (d_re <= tol && d_re >= -tol) ? want : mem[n][0];
      got_im = (d_im <= tol && d_im >= -tol) ? 16'h0000 : mem[n][1];
      check($sformatf("%s_re%0d", name, n), 64'(got_re), 64'(want));
      check($sformatf("%s_im%0d", name, n), 64'(got_im), 64'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rd_seen, wr_seen;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_stage", 64'(stage), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // impulse, pulsed start with an extra start request mid-run
    load(0);
    run_fft(1'b0, 1'b1);
    check_bins("imp", IMP_RE, IMP_RE, 0);

    // DC, start held high through the whole transform
    load(1);
    run_fft(1'b1, 1'b0);
    check_bins("dc", DC_RE, 16'h0000, 2);

    // random data: scoreboard checks every write
    load(2);
    run_fft(1'b0, 1'b0);

    // fresh pulse after done: identical impulse result
    load(0);
    run_fft(1'b0, 1'b0);
    check_bins("imp2", IMP_RE, IMP_RE, 0);

    // reset in the middle of a transform
    load(2);
    push_reads();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_stage", 64'(stage), 64'd0);
    check("abort_rd_addr", 64'({rd_addr_a, rd_addr_b, twid_idx}), 64'd0);
    check("abort_wr_data", 64'({wr_data_a, wr_data_b}), 64'd0);
    check("abort_bfly", 64'({bfly_a_o, bfly_b_o}), 64'd0);
    rq.delete();
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    rd_seen = 0;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en) rd_seen++;
      if (wr_en) wr_seen++;
    end
    $display("after abort: reads=%0d writes=%0d busy=%0d", rd_seen, wr_seen, busy);
    check("abort_no_rd", 64'(rd_seen), 64'd0);
    check("abort_no_wr", 64'(wr_seen), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
